regfile_wb_arbiter: RTL and testbench

// - Write-side initiator for the 32x32 register file: drives WEN/wsel/wdat.
// - Merges two writeback sources into the file's single write port:
//   - the in-order pipeline writeback (no backpressure);
//   - a long-latency unit (mult/div) with a valid/ready handshake.
// - Long-latency results wait in a FIFO and drain on idle write-port cycles.
// - Exports a pending-destination mask so hazard logic can stall readers.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority; long-latency results queue and drain on idle cycles.
// Optional stall-cycle statistics counter enabled by defining WB_STATS_EN.
module regfile_wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int MAX_STARVE = 8,
   parameter int DATA_W     = 32
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     pipe_wen,
   input  logic [4:0]               pipe_wsel,
   input  logic [DATA_W-1:0]        pipe_wdat,
   input  logic                     lu_valid,
   output logic                     lu_ready,
   input  logic [4:0]               lu_wsel,
   input  logic [DATA_W-1:0]        lu_wdat,
   output logic                     rf_WEN,
   output logic [4:0]               rf_wsel,
   output logic [DATA_W-1:0]        rf_wdat,
   output logic [31:0]              pend_mask,
   output logic                     stall_req,
   output logic [$clog2(DEPTH):0]   q_count
`ifdef WB_STATS_EN
   ,
   output logic [15:0]              stat_stall
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] MAX_C   = SW'(MAX_STARVE);

   function automatic logic [SW-1:0] sat_inc_starve(input logic [SW-1:0] v);
      return (v >= MAX_C) ? MAX_C : v + 1'b1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [4:0]        mem_sel [DEPTH];
   logic [DATA_W-1:0] mem_dat [DEPTH];
   logic [DEPTH-1:0]  slot_vld;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     starve_cnt, starve_nxt;

   logic pipe_req_p0, pop_p0, push_p0;
   logic              wen_p1;
   logic [4:0]        wsel_p1;
   logic [DATA_W-1:0] wdat_p1;

   // Stage p0: selection from registered occupancy; FIFO never falls through
   assign lu_ready    = (cnt < DEPTH_C);
   assign pipe_req_p0 = pipe_wen && (pipe_wsel != 5'd0);
   assign pop_p0      = !pipe_req_p0 && (cnt != '0);
   assign push_p0     = lu_valid && lu_ready && (lu_wsel != 5'd0);
   assign starve_nxt  = ((cnt == '0) || pop_p0) ? '0 : sat_inc_starve(starve_cnt);

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (slot_vld[i]) pend_mask[mem_sel[i]] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (push_p0) begin
         mem_sel[wr_ptr] <= lu_wsel;
         mem_dat[wr_ptr] <= lu_wdat;
      end
   end

   // Stage p1: registered write port and FIFO/starvation state
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wen_p1     <= 1'b0;
         wsel_p1    <= '0;
         wdat_p1    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         slot_vld   <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         if (pipe_req_p0) begin
            wen_p1  <= 1'b1;
            wsel_p1 <= pipe_wsel;
            wdat_p1 <= pipe_wdat;
         end else if (pop_p0) begin
            wen_p1  <= 1'b1;
            wsel_p1 <= mem_sel[rd_ptr];
            wdat_p1 <= mem_dat[rd_ptr];
         end else begin
            wen_p1  <= 1'b0;
         end
         if (pop_p0) begin
            slot_vld[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + 1'b1;
         end
         if (push_p0) begin
            slot_vld[wr_ptr] <= 1'b1;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         case ({push_p0, pop_p0})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         starve_cnt <= starve_nxt;
         stall_req  <= (starve_nxt >= MAX_C);
      end
   end

`ifdef WB_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)          stat_stall <= '0;
      else if (stall_req) stat_stall <= sat_inc16(stat_stall);
   end
`endif

   assign rf_WEN  = wen_p1;
   assign rf_wsel = wsel_p1;
   assign rf_wdat = wdat_p1;
   assign q_count = cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter, plus a reset-mid-drain sequence.
module tb_regfile_wb_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        pipe_wen;
   logic [4:0]  pipe_wsel;
   logic [31:0] pipe_wdat;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_wsel;
   logic [31:0] lu_wdat;
   logic        rf_WEN;
   logic [4:0]  rf_wsel;
   logic [31:0] rf_wdat;
   logic [31:0] pend_mask;
   logic        stall_req;
   logic [2:0]  q_count;
`ifdef WB_STATS_EN
   logic [15:0] stat_stall;
`endif

   regfile_wb_arbiter #(.DEPTH(4), .MAX_STARVE(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat),
      .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
      .pend_mask(pend_mask), .stall_req(stall_req), .q_count(q_count)
`ifdef WB_STATS_EN
      , .stat_stall(stat_stall)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        pw;
      logic [4:0]  ps;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  ls;
      logic [31:0] ld;
      logic        ew;
      logic [4:0]  esel;
      logic [31:0] edat;
      logic [31:0] epend;
      logic [2:0]  eq;
      logic        erdy;
      logic        estall;
   } vec_t;

   localparam int NV = 25;
   vec_t vec [NV];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                        input logic lv, input logic [4:0] ls, input logic [31:0] ld);
      pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd;
      lu_valid = lv; lu_wsel = ls; lu_wdat = ld;
   endtask

   initial begin
      //          pw ps     pd        lv ls     ld        ew esel   edat      epend     eq  rdy st
      vec[0]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    32'h0,    3'd0, 1'b1, 1'b0};
      vec[1]  = '{1'b1, 5'd5,  32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'hDEAD, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'hDEAD, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[3]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 32'h1234, 1'b0, 5'd5,  32'hDEAD, 32'h80,   3'd1, 1'b1, 1'b0};
      vec[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7,  32'h1234, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7,  32'h1234, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[6]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'h5555, 1'b0, 5'd7,  32'h1234, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[7]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7,  32'h1234, 32'h0,    3'd0, 1'b1, 1'b0};
      vec[8]  = '{1'b1, 5'd3,  32'h33,   1'b1, 5'd9, 32'h99,   1'b1, 5'd3,  32'h33,   32'h200,  3'd1, 1'b1, 1'b0};
      vec[9]  = '{1'b1, 5'd0,  32'hFF,   1'b0, 5'd0, 32'h0,    1'b1, 5'd9,  32'h99,   32'h0,    3'd0, 1'b1, 1'b0};
      vec[10] = '{1'b1, 5'd10, 32'hA0,   1'b1, 5'd1, 32'h11,   1'b1, 5'd10, 32'hA0,   32'h2,    3'd1, 1'b1, 1'b0};
      vec[11] = '{1'b1, 5'd10, 32'hA1,   1'b1, 5'd2, 32'h22,   1'b1, 5'd10, 32'hA1,   32'h6,    3'd2, 1'b1, 1'b0};
      vec[12] = '{1'b1, 5'd10, 32'hA2,   1'b1, 5'd3, 32'h33,   1'b1, 5'd10, 32'hA2,   32'hE,    3'd3, 1'b1, 1'b0};
      vec[13] = '{1'b1, 5'd10, 32'hA3,   1'b1, 5'd4, 32'h44,   1'b1, 5'd10, 32'hA3,   32'h1E,   3'd4, 1'b0, 1'b0};
      vec[14] = '{1'b1, 5'd10, 32'hA4,   1'b1, 5'd5, 32'h55,   1'b1, 5'd10, 32'hA4,   32'h1E,   3'd4, 1'b0, 1'b0};
      vec[15] = '{1'b1, 5'd10, 32'hA5,   1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA5,   32'h1E,   3'd4, 1'b0, 1'b0};
      vec[16] = '{1'b1, 5'd10, 32'hA6,   1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA6,   32'h1E,   3'd4, 1'b0, 1'b0};
      vec[17] = '{1'b1, 5'd10, 32'hA7,   1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA7,   32'h1E,   3'd4, 1'b0, 1'b0};
      vec[18] = '{1'b1, 5'd10, 32'hA8,   1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA8,   32'h1E,   3'd4, 1'b0, 1'b1};
      vec[19] = '{1'b1, 5'd10, 32'hA9,   1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA9,   32'h1E,   3'd4, 1'b0, 1'b1};
      vec[20] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd6, 32'h66,   1'b1, 5'd1,  32'h11,   32'h1C,   3'd3, 1'b1, 1'b0};
      vec[21] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd2,  32'h22,   32'h18,   3'd2, 1'b1, 1'b0};
      vec[22] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3,  32'h33,   32'h10,   3'd1, 1'b1, 1'b0};
      vec[23] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd4,  32'h44,   32'h0,    3'd0, 1'b1, 1'b0};
      vec[24] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd4,  32'h44,   32'h0,    3'd0, 1'b1, 1'b0};

      nRST = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #3;
      chk("rst_wen",   0, 32'(rf_WEN),    32'h0);
      chk("rst_wsel",  0, 32'(rf_wsel),   32'h0);
      chk("rst_wdat",  0, rf_wdat,        32'h0);
      chk("rst_pend",  0, pend_mask,      32'h0);
      chk("rst_qcnt",  0, 32'(q_count),   32'h0);
      chk("rst_rdy",   0, 32'(lu_ready),  32'h1);
      chk("rst_stall", 0, 32'(stall_req), 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].pw, vec[i].ps, vec[i].pd, vec[i].lv, vec[i].ls, vec[i].ld);
         @(negedge CLK);
         chk("wen",   i, 32'(rf_WEN),    32'(vec[i].ew));
         chk("wsel",  i, 32'(rf_wsel),   32'(vec[i].esel));
         chk("wdat",  i, rf_wdat,        vec[i].edat);
         chk("pend",  i, pend_mask,      vec[i].epend);
         chk("qcnt",  i, 32'(q_count),   32'(vec[i].eq));
         chk("rdy",   i, 32'(lu_ready),  32'(vec[i].erdy));
         chk("stall", i, 32'(stall_req), 32'(vec[i].estall));
      end
`ifdef WB_STATS_EN
      chk("stat_after_table", 0, 32'(stat_stall), 32'd2);
`endif

      // Reset mid-drain: fill four entries under pipe writes, drain one, then reset
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd10, 32'hB0, 1'b1, 5'(12 + i), 32'(32'hC0 + i));
         @(negedge CLK);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge CLK);
      chk("drain_wen",  0, 32'(rf_WEN),  32'h1);
      chk("drain_wsel", 0, 32'(rf_wsel), 32'd12);
      chk("drain_qcnt", 0, 32'(q_count), 32'd3);
      chk("drain_pend", 0, pend_mask,    32'h0000_E000);
      #2 nRST = 1'b0;
      #1;
      chk("mid_rst_qcnt", 0, 32'(q_count),   32'h0);
      chk("mid_rst_pend", 0, pend_mask,      32'h0);
      chk("mid_rst_wen",  0, 32'(rf_WEN),    32'h0);
      chk("mid_rst_wsel", 0, 32'(rf_wsel),   32'h0);
      chk("mid_rst_rdy",  0, 32'(lu_ready),  32'h1);
      chk("mid_rst_stall",0, 32'(stall_req), 32'h0);
`ifdef WB_STATS_EN
      chk("mid_rst_stat", 0, 32'(stat_stall), 32'h0);
`endif
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      chk("post_rst_wen",  0, 32'(rf_WEN),  32'h0);
      chk("post_rst_qcnt", 0, 32'(q_count), 32'h0);
      chk("post_rst_pend", 0, pend_mask,    32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
